// File: rtl/mux_arbiter_rr4_pkg.sv
// mux_arbiter_rr4_pkg: shared state encoding and sizing constants for the 4-way round-robin arbiter.
package mux_arbiter_rr4_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/mux_arbiter_rr4_pick.sv
// rr_pick4: rotating-priority encoder, first unmasked request at or after ptr wins.
module rr_pick4
  import mux_arbiter_rr4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);
  logic [NUM_REQ-1:0] live;
  always_comb begin
    live = req & ~mask;
    any = |live;
    idx = '0;
    // Walk farthest-first so the nearest candidate to ptr is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (live[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
  end
endmodule

// File: rtl/mux_arbiter_rr4.sv
// mux_arbiter_rr4: round-robin arbiter driving a shared 4:1 word mux with valid/ready and bounded locked bursts.
module mux_arbiter_rr4
  import mux_arbiter_rr4_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] lock_i,
  input  logic [WIDTH-1:0]   data0_i,
  input  logic [WIDTH-1:0]   data1_i,
  input  logic [WIDTH-1:0]   data2_i,
  input  logic [WIDTH-1:0]   data3_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] ack_o
);
  state_t state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n, sel_n, pick_ptr, widx;
  logic [NUM_REQ-1:0] gnt_n, mask;
  logic [3:0] beat_cnt, beat_n;
  logic busy, xfer, cont, rel, any;
  assign busy = state == BUSY;
  assign data_o = sel_o[1] ? (sel_o[0] ? data3_i : data2_i) : (sel_o[0] ? data1_i : data0_i);
  assign valid_o = busy & req_i[sel_o];
  assign xfer = valid_o & ready_i;
  assign ack_o = xfer ? NUM_REQ'(1) << sel_o : '0;
  assign cont = xfer & lock_i[sel_o] & ({1'b0, beat_cnt} + 5'd1 < 5'(MAX_BURST));
  assign rel = busy & (~req_i[sel_o] | (xfer & ~cont));
  // On release the just-served requester is masked so it cannot win the very next grant.
  assign pick_ptr = rel ? sel_o + SEL_W'(1) : ptr;
  assign mask = rel ? NUM_REQ'(1) << sel_o : '0;
  rr_pick4 u_pick (
    .req  (req_i),
    .mask (mask),
    .ptr  (pick_ptr),
    .any  (any),
    .idx  (widx)
  );
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    sel_n = sel_o;
    gnt_n = gnt_o;
    beat_n = beat_cnt;
    if (cont) beat_n = beat_cnt + 4'd1;
    else if (!busy || rel) begin
      ptr_n = pick_ptr;
      state_n = any ? BUSY : IDLE;
      sel_n = any ? widx : sel_o;
      gnt_n = any ? NUM_REQ'(1) << widx : '0;
      beat_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      sel_o <= '0;
      gnt_o <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      sel_o <= sel_n;
      gnt_o <= gnt_n;
      beat_cnt <= beat_n;
    end
  end
endmodule

// File: tb/tb_mux_arbiter_rr4.sv
// tb_mux_arbiter_rr4: directed vector table plus a backpressure sequence for the round-robin arbiter.
module tb_mux_arbiter_rr4;
  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] lock;
    logic       ready;
    logic       valid;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic [3:0] ack;
  } vec_t;

  logic clk = 0;
  logic rst_n;
  logic [3:0] req_i, lock_i, gnt_o, ack_o;
  logic ready_i, valid_o;
  logic [31:0] d [4];
  logic [31:0] data_o;
  logic [1:0] sel_o;
  int checks = 0;
  int errors = 0;
  vec_t tv [$];

  always #5 clk = ~clk;

  mux_arbiter_rr4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_i),
    .lock_i  (lock_i),
    .data0_i (d[0]),
    .data1_i (d[1]),
    .data2_i (d[2]),
    .data3_i (d[3]),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .sel_o   (sel_o),
    .gnt_o   (gnt_o),
    .ack_o   (ack_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic rd,
                             input logic vl, input logic [1:0] s, input logic [3:0] g, input logic [3:0] a);
    vec_t t;
    t.rst_n = r; t.req = rq; t.lock = lk; t.ready = rd;
    t.valid = vl; t.sel = s; t.gnt = g; t.ack = a;
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) d[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
    tv.push_back(v(0, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b0100, 4'b0000, 1, 1, 2, 4'b0100, 4'b0100));
    tv.push_back(v(1, 4'b0000, 4'b0000, 1, 0, 2, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b1111, 4'b0000, 1, 0, 2, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b1111, 4'b0000, 1, 1, 3, 4'b1000, 4'b1000));
    tv.push_back(v(1, 4'b1111, 4'b0000, 1, 1, 0, 4'b0001, 4'b0001));
    tv.push_back(v(1, 4'b1111, 4'b0000, 1, 1, 1, 4'b0010, 4'b0010));
    tv.push_back(v(1, 4'b1111, 4'b0000, 1, 1, 2, 4'b0100, 4'b0100));
    tv.push_back(v(1, 4'b1111, 4'b0000, 1, 1, 3, 4'b1000, 4'b1000));
    tv.push_back(v(1, 4'b1111, 4'b0000, 1, 1, 0, 4'b0001, 4'b0001));
    tv.push_back(v(1, 4'b0010, 4'b0000, 0, 1, 1, 4'b0010, 4'b0000));
    tv.push_back(v(1, 4'b0010, 4'b0000, 0, 1, 1, 4'b0010, 4'b0000));
    tv.push_back(v(1, 4'b0010, 4'b0000, 0, 1, 1, 4'b0010, 4'b0000));
    tv.push_back(v(1, 4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 4'b0010));
    tv.push_back(v(1, 4'b0000, 4'b0000, 1, 0, 1, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b0011, 4'b0001, 1, 0, 1, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b0011, 4'b0001, 1, 1, 0, 4'b0001, 4'b0001));
    tv.push_back(v(1, 4'b0011, 4'b0001, 1, 1, 0, 4'b0001, 4'b0001));
    tv.push_back(v(1, 4'b0011, 4'b0001, 1, 1, 0, 4'b0001, 4'b0001));
    tv.push_back(v(1, 4'b0011, 4'b0001, 1, 1, 0, 4'b0001, 4'b0001));
    tv.push_back(v(1, 4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 4'b0010));
    tv.push_back(v(1, 4'b0100, 4'b0100, 0, 0, 1, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b0100, 4'b0100, 1, 1, 2, 4'b0100, 4'b0100));
    tv.push_back(v(0, 4'b0100, 4'b0100, 0, 1, 2, 4'b0100, 4'b0000));
    tv.push_back(v(1, 4'b0110, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b0010, 4'b0000, 1, 1, 1, 4'b0010, 4'b0010));
    tv.push_back(v(1, 4'b0000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b1000, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000));
    tv.push_back(v(1, 4'b1000, 4'b0000, 0, 1, 3, 4'b1000, 4'b0000));
    tv.push_back(v(1, 4'b0001, 4'b0000, 0, 0, 3, 4'b1000, 4'b0000));
    tv.push_back(v(1, 4'b0001, 4'b0000, 1, 1, 0, 4'b0001, 4'b0001));

    rst_n = 0; req_i = '0; lock_i = '0; ready_i = 0;
    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      @(negedge clk);
      rst_n = tv[i].rst_n; req_i = tv[i].req; lock_i = tv[i].lock; ready_i = tv[i].ready;
      #1;
      chk($sformatf("row%0d valid", i), 32'(valid_o), 32'(tv[i].valid));
      chk($sformatf("row%0d sel", i), 32'(sel_o), 32'(tv[i].sel));
      chk($sformatf("row%0d gnt", i), 32'(gnt_o), 32'(tv[i].gnt));
      chk($sformatf("row%0d ack", i), 32'(ack_o), 32'(tv[i].ack));
      chk($sformatf("row%0d data", i), data_o, d[tv[i].sel]);
    end

    // Idle with ptr=1: grant requester 1 and hold it under backpressure while its word changes.
    @(negedge clk);
    req_i = 4'b0010; lock_i = '0; ready_i = 0;
    #1 chk("bp idle gnt", 32'(gnt_o), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d[1] = 32'h5EED_0000 + 32'(k);
      #1;
      chk($sformatf("bp%0d gnt", k), 32'(gnt_o), 32'h2);
      chk($sformatf("bp%0d data", k), data_o, 32'h5EED_0000 + 32'(k));
      chk($sformatf("bp%0d ack", k), 32'(ack_o), 32'h0);
      chk($sformatf("bp%0d valid", k), 32'(valid_o), 32'h1);
    end
    @(negedge clk);
    ready_i = 1;
    #1 chk("bp ack", 32'(ack_o), 32'h2);
    @(negedge clk);
    req_i = '0;
    #1 chk("bp release gnt", 32'(gnt_o), 32'h0);
    chk("bp release valid", 32'(valid_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arbiter_rr4.md
Name: mux_arbiter_rr4

Overview:
- Round-robin arbiter that shares one 32-bit 4:1 select datapath among four requesters.
- Each requester presents a request and a 32-bit word. The block grants one requester and drives the mux select. It presents the selected word to a single downstream consumer with valid/ready.
- Used wherever four pipeline sources contend for one shared port, for example a register-file write port or a memory-request port.
- Supports locked multi-beat bursts with a bounded length, so no requester can starve the others.

Parameters:
- WIDTH, 32, data width of each requester word and of data_o.
- MAX_BURST, 4, maximum consecutive beats granted to one locked requester before a forced release. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_i  input  4  request per requester; bit n belongs to requester n.
- lock_i  input  4  per requester: keep the grant after the current beat (burst).
- data0_i, data1_i, data2_i, data3_i  input  WIDTH each  requester words.
- ready_i  input  1  downstream accepts the word this cycle.
- valid_o  output  1  data_o holds a word for downstream.
- data_o  output  WIDTH  selected requester word.
- sel_o  output  2  current mux select, equal to the granted index.
- gnt_o  output  4  one-hot grant; all zero when idle.
- ack_o  output  4  one-cycle pulse on bit sel_o when a beat transfers (valid_o & ready_i).

Behaviour:
- Reset (synchronous, rst_n low at a clk edge):
  - state=IDLE, ptr=0, sel_o=0, gnt_o=0, beat_cnt=0.
  - valid_o=0, ack_o=0, data_o=data0_i (the mux follows sel=0).
  - Reset mid-burst drops the grant with no ack.
- States are IDLE and BUSY.
- Priority search:
  - Search starts at index ptr and goes ptr, ptr+1, ptr+2, ptr+3, mod 4.
  - The winner is the first index with req_i set.
  - Winner logic is combinational. The grant is registered.
- IDLE: if any req_i bit is set, register sel=winner, gnt=onehot(winner), beat_cnt=0, then go to BUSY. Request at cycle N gives valid_o at N+1.
- BUSY outputs:
  - valid_o = req_i[sel_o]. data_o is the live mux of data*_i by the registered sel_o, with no extra latency.
  - ack_o[sel_o] = valid_o & ready_i, combinational. All other ack_o bits are 0.
- BUSY, beat transfers (valid_o & ready_i):
  - Burst continues when lock_i[sel_o] & (beat_cnt+1 < MAX_BURST). Grant is held, beat_cnt increments, state stays BUSY.
  - Otherwise the grant is released:
    - ptr = sel_o+1 mod 4.
    - The search runs in the same cycle with the new ptr, using current req_i with bit sel_o masked off.
    - If a winner exists, grant it next cycle and stay BUSY (back-to-back, no bubble).
    - If no winner exists, go to IDLE with gnt_o=0.
- BUSY, req_i[sel_o] low: this is an abort.
  - No ack.
  - Release as above: ptr advances and re-arbitration runs with no bubble.
- BUSY, no transfer and request held: all state is held. The grant is stable while ready_i is low.
- A requester whose grant was just released is not re-granted in the following cycle, even if it is the only requester. It re-enters arbitration one cycle later, from IDLE.
- MAX_BURST=1 makes lock_i have no effect.
- beat_cnt is 4 bits wide. It never exceeds MAX_BURST-1.
- ptr changes only on release or abort. It does not change while in IDLE.

Decomposition:
- Shared package holds:
  - the state encoding localparams: IDLE=1'b0, BUSY=1'b1;
  - the NUM_REQ=4 constant;
  - the select width SEL_W=2.
- Natural sub-module rr_pick4:
  - combinational rotating-priority encoder;
  - inputs req[3:0], mask[3:0], ptr[1:0];
  - outputs any and idx[1:0].
- The data path reuses the team's existing 32-bit 4:1 mux.

Test Plan:
- Reset then single request: req_i=0100 with ready_i=1.
  - valid_o=1 one cycle later, with sel_o=2, data_o=data2_i, ack_o=0100.
  - Next cycle: IDLE, gnt_o=0, ptr=3.
- All request, no lock: req_i=1111 held with ready_i=1 and ptr=0.
  - Grants go 0,1,2,3,0 on consecutive cycles, with one ack per cycle and no bubbles.
- Backpressure: grant requester 1, ready_i=0 for 3 cycles with data1_i changing.
  - gnt_o=0010 stays stable and data_o tracks data1_i.
  - Single ack when ready_i=1.
- Burst cap: MAX_BURST=4, lock_i=0001, req_i=0011, ready_i=1.
  - Requester 0 gets exactly 4 consecutive acks.
  - Then requester 1 is granted with no bubble.
- Abort and reset: grant requester 3, then drop req_i[3] while ready_i=0.
  - No ack; the next requester is granted.
  - rst_n low mid-burst: all outputs return to their reset values on the next edge, and ptr=0.
